// File: rtl/axi4_lite_slave_read_responder.sv
// AXI4-Lite slave read engine: 2-entry AR queue, local word array with
// backdoor preload, programmable-latency single-beat R responses.
module axi4_lite_slave_read_responder #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_DEPTH     = 16,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [3:0]                   arid,
  input  logic [ADDRESS_WIDTH-1:0]     araddr,
  input  logic [2:0]                   arprot,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [3:0]                   rid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] bd_widx,
  input  logic [DATA_WIDTH-1:0]        bd_wdata
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFS_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDRESS_WIDTH:0] ADDR_LIMIT = (ADDRESS_WIDTH+1)'(MEM_DEPTH * BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, LOAD, RESP} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               wait_q, wait_d;
  logic                     pop, load;
  logic                     push;

  logic [3:0]               fifo_id   [2];
  logic [ADDRESS_WIDTH-1:0] fifo_addr [2];
  logic                     wr_ptr, rd_ptr;
  logic [1:0]               count;
  logic                     ready_en;

  logic [3:0]               cur_id;
  logic [ADDRESS_WIDTH-1:0] cur_addr;

  logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];

  logic                     misaligned, out_of_range;
  logic [IDX_W-1:0]         idx;
  logic [DATA_WIDTH-1:0]    rdata_d;
  logic [1:0]               rresp_d;

  logic                     unused_prot;
  assign unused_prot = ^arprot;

  // arready depends only on registered state; ready_en keeps it low until the
  // first edge after reset release.
  assign arready = ready_en && (count < 2'd2);
  assign push    = arvalid && arready;
  assign rlast   = rvalid;

  // Request queue, ready enable and popped-request holding registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_id[i]   <= '0;
        fifo_addr[i] <= '0;
      end
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      ready_en <= 1'b0;
      cur_id   <= '0;
      cur_addr <= '0;
    end else begin
      ready_en <= 1'b1;
      if (push) begin
        fifo_id[wr_ptr]   <= arid;
        fifo_addr[wr_ptr] <= araddr;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        cur_id   <= fifo_id[rd_ptr];
        cur_addr <= fifo_addr[rd_ptr];
        rd_ptr   <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Word array: cleared on reset, written only through the backdoor port
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (bd_we) begin
      mem[bd_widx] <= bd_wdata;
    end
  end

  // FSM state and latency counter registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; WAIT exits when the counter would reach zero so the
  // pop-to-LOAD gap is exactly READ_LATENCY cycles.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pop     = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != 2'd0) begin
          pop = 1'b1;
          if (READ_LATENCY == 1) begin
            state_d = LOAD;
          end else begin
            wait_d  = 4'(READ_LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q <= 4'd1) state_d = LOAD;
      end
      LOAD: begin
        load    = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address decode of the popped request
  always_comb begin
    misaligned   = |cur_addr[OFS_W-1:0];
    out_of_range = {1'b0, cur_addr} >= ADDR_LIMIT;
    idx          = cur_addr[OFS_W +: IDX_W];
    rresp_d      = RESP_SLVERR;
    rdata_d      = '0;
    if (!misaligned && !out_of_range) begin
      rresp_d = RESP_OKAY;
      rdata_d = mem[idx];
    end
  end

  // R channel registers: captured in LOAD, held until the handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid <= 1'b0;
      rid    <= '0;
      rdata  <= '0;
      rresp  <= '0;
    end else if (load) begin
      rvalid <= 1'b1;
      rid    <= cur_id;
      rdata  <= rdata_d;
      rresp  <= rresp_d;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_read_responder.sv
// Directed bench for axi4_lite_slave_read_responder (32-bit data, 16 words).
module tb_axi4_lite_slave_read_responder;

  localparam int LAT = 1;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        bd_we;
  logic [3:0]  bd_widx;
  logic [31:0] bd_wdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [16];

  axi4_lite_slave_read_responder #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16), .READ_LATENCY(LAT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .arid(arid), .araddr(araddr), .arprot(arprot),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready), .bd_we(bd_we),
    .bd_widx(bd_widx), .bd_wdata(bd_wdata)
  );

  always #5 aclk = ~aclk;

  // All stimulus tasks start and end 1ns after a rising edge.
  task automatic backdoor(input logic [3:0] i, input logic [31:0] d);
    bd_we = 1'b1; bd_widx = i; bd_wdata = d;
    @(posedge aclk); #1;
    bd_we = 1'b0;
    model[i] = d;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, output logic ok);
    logic rdy;
    arvalid = 1'b1; arid = id; araddr = addr; arprot = 3'b010; ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk); rdy = arready;
      @(posedge aclk); #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    arvalid = 1'b0;
  endtask

  task automatic r_take(output logic [3:0] id, output logic [31:0] d,
                        output logic [1:0] resp, output logic ok);
    ok = 1'b0; id = '0; d = '0; resp = '0;
    rready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk);
      if (rvalid) begin ok = 1'b1; id = rid; d = rdata; resp = rresp; end
      @(posedge aclk); #1;
      if (ok) break;
    end
    rready = 1'b0;
  endtask

  task automatic test_reset;
    aresetn = 1'b0; arvalid = 1'b0; arid = '0; araddr = '0; arprot = '0;
    rready = 1'b0; bd_we = 1'b0; bd_widx = '0; bd_wdata = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    #12;
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL reset_arready got %b want 0", arready); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
    checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL reset_rlast got %b want 0", rlast); end
    checks++; if ({rid, rdata, rresp} !== 38'h0) begin errors++; $display("FAIL reset_rfields got %h want 0", {rid, rdata, rresp}); end
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_release_arready got %b want 1", arready); end
  endtask

  task automatic test_basic;
    logic ok; int n;
    logic [3:0] id; logic [31:0] d; logic [1:0] resp;
    backdoor(4'd3, 32'hDEADBEEF);
    rready = 1'b0;
    ar_send(4'd5, 32'h0C, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_ar got %b want 1", ok); end
    n = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (rvalid) break;
      @(posedge aclk); #1; n++;
    end
    checks++; if (n != LAT + 2) begin errors++; $display("FAIL basic_latency got %0d want %0d", n, LAT + 2); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rdata got %h want deadbeef", rdata); end
    checks++; if (rid !== 4'd5) begin errors++; $display("FAIL basic_rid got %h want 5", rid); end
    checks++; if (rresp !== 2'b00) begin errors++; $display("FAIL basic_rresp got %b want 00", rresp); end
    checks++; if (rlast !== 1'b1) begin errors++; $display("FAIL basic_rlast got %b want 1", rlast); end
    @(posedge aclk); #1;
    r_take(id, d, resp, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_take got %b want 1", ok); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL basic_rvalid_drop got %b want 0", rvalid); end
  endtask

  task automatic test_errors;
    logic ok;
    logic [3:0] id; logic [31:0] d; logic [1:0] resp;
    logic [31:0] addrs [4];
    logic [1:0]  wresp [4];
    logic [31:0] wdata [4];
    addrs = '{32'h40, 32'h06, 32'h3C, 32'h8000_0004};
    wresp = '{2'b10, 2'b10, 2'b00, 2'b10};
    wdata = '{32'h0, 32'h0, 32'hCAFEF00D, 32'h0};
    backdoor(4'd1, 32'h11111111);
    backdoor(4'd15, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      ar_send(4'(7 + i), addrs[i], ok);
      r_take(id, d, resp, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL err_take[%0d] got %b want 1", i, ok); end
      checks++; if (resp !== wresp[i]) begin errors++; $display("FAIL err_rresp[%0d] got %b want %b", i, resp, wresp[i]); end
      checks++; if (d !== wdata[i]) begin errors++; $display("FAIL err_rdata[%0d] got %h want %h", i, d, wdata[i]); end
      checks++; if (id !== 4'(7 + i)) begin errors++; $display("FAIL err_rid[%0d] got %h want %h", i, id, 4'(7 + i)); end
    end
  endtask

  task automatic test_backpressure;
    logic ok;
    logic [3:0] id; logic [31:0] d; logic [1:0] resp;
    for (int i = 1; i <= 4; i++) backdoor(4'(i), 32'hA0000000 + 32'(i));
    rready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      ar_send(4'(i), 32'(4 * i), ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_ar[%0d] got %b want 1", i, ok); end
    end
    arvalid = 1'b1; arid = 4'd4; araddr = 32'h10;
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      checks++; if (arready !== 1'b0) begin errors++; $display("FAIL bp_full_arready[%0d] got %b want 0", c, arready); end
      @(posedge aclk); #1;
    end
    rready = 1'b1;
    @(negedge aclk);
    checks++; if ({rvalid, rid, rdata} !== {1'b1, 4'd1, 32'hA0000001}) begin
      errors++; $display("FAIL bp_first_r got %h want %h", {rvalid, rid, rdata}, {1'b1, 4'd1, 32'hA0000001}); end
    @(posedge aclk); #1;
    rready = 1'b0;
    @(negedge aclk);
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL bp_pop_cycle_arready got %b want 0", arready); end
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL bp_reopen_arready got %b want 1", arready); end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      r_take(id, d, resp, ok);
      checks++; if ({ok, id, d, resp} !== {1'b1, 4'(i), 32'hA0000000 + 32'(i), 2'b00}) begin
        errors++; $display("FAIL bp_order[%0d] got %h want %h", i, {ok, id, d, resp}, {1'b1, 4'(i), 32'hA0000000 + 32'(i), 2'b00}); end
    end
  endtask

  task automatic test_random;
    logic [3:0]  q_id   [$];
    logic [31:0] q_data [$];
    logic [1:0]  q_resp [$];
    int got;
    for (int i = 0; i < 16; i++) backdoor(4'(i), $urandom);
    got = 0;
    fork
      begin : producer
        logic ok; logic [31:0] a; int r;
        for (int i = 0; i < 100; i++) begin
          r = $urandom_range(0, 7);
          if (r == 0)      a = 32'h40 + 32'(4 * $urandom_range(0, 3));
          else if (r == 1) a = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
          else             a = 32'(4 * $urandom_range(0, 15));
          ar_send(4'(i), a, ok);
          checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rnd_ar[%0d] got %b want 1", i, ok); end
          q_id.push_back(4'(i));
          if (a[1:0] != 2'b00 || a >= 32'h40) begin
            q_data.push_back(32'h0); q_resp.push_back(2'b10);
          end else begin
            q_data.push_back(model[a[5:2]]); q_resp.push_back(2'b00);
          end
        end
      end
      begin : consumer
        logic stalled; logic [37:0] held; logic [37:0] want;
        stalled = 1'b0; held = '0;
        for (int c = 0; c < 4000 && got < 100; c++) begin
          rready = 1'($urandom_range(0, 1));
          @(negedge aclk);
          if (rvalid) begin
            if (stalled) begin
              checks++; if ({rid, rdata, rresp} !== held) begin
                errors++; $display("FAIL rnd_stable got %h want %h", {rid, rdata, rresp}, held); end
            end
            if (rready) begin
              checks++;
              if (q_id.size() == 0) begin
                errors++; $display("FAIL rnd_extra_beat got %h want none", {rid, rdata, rresp});
              end else begin
                want = {q_id.pop_front(), q_data.pop_front(), q_resp.pop_front()};
                if ({rid, rdata, rresp} !== want) begin
                  errors++; $display("FAIL rnd_beat[%0d] got %h want %h", got, {rid, rdata, rresp}, want); end
              end
              got++; stalled = 1'b0;
            end else begin
              stalled = 1'b1; held = {rid, rdata, rresp};
            end
          end
          @(posedge aclk); #1;
        end
        rready = 1'b0;
      end
    join
    checks++; if (got != 100 || q_id.size() != 0) begin
      errors++; $display("FAIL rnd_count got %0d beats %0d pending want 100 beats 0 pending", got, q_id.size()); end
  endtask

  task automatic test_bd_collision;
    logic ok;
    logic [3:0] id; logic [31:0] d; logic [1:0] resp;
    backdoor(4'd2, 32'h00000022);
    rready = 1'b0;
    ar_send(4'd3, 32'h08, ok);
    @(posedge aclk); #1;
    bd_we = 1'b1; bd_widx = 4'd2; bd_wdata = 32'h22222222;
    @(posedge aclk); #1;
    bd_we = 1'b0; model[2] = 32'h22222222;
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL bdc_load_edge got %b want 1", rvalid); end
    r_take(id, d, resp, ok);
    checks++; if ({ok, id, d} !== {1'b1, 4'd3, 32'h00000022}) begin
      errors++; $display("FAIL bdc_old got %h want %h", {ok, id, d}, {1'b1, 4'd3, 32'h00000022}); end
    ar_send(4'd4, 32'h08, ok);
    r_take(id, d, resp, ok);
    checks++; if ({ok, id, d} !== {1'b1, 4'd4, 32'h22222222}) begin
      errors++; $display("FAIL bdc_new got %h want %h", {ok, id, d}, {1'b1, 4'd4, 32'h22222222}); end
  endtask

  task automatic test_async_reset;
    logic ok; logic seen;
    logic [3:0] id; logic [31:0] d; logic [1:0] resp;
    backdoor(4'd0, 32'h0BAD0000);
    rready = 1'b0;
    ar_send(4'd1, 32'h0, ok);
    ar_send(4'd2, 32'h4, ok);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (rvalid) begin seen = 1'b1; break; end
      @(posedge aclk); #1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ars_resp_reached got %b want 1", seen); end
    #2 aresetn = 1'b0;
    #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL ars_rvalid_drop got %b want 0", rvalid); end
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL ars_arready_low got %b want 0", arready); end
    for (int i = 0; i < 16; i++) model[i] = '0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL ars_arready_back got %b want 1", arready); end
    rready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk); if (rvalid) seen = 1'b1;
      @(posedge aclk); #1;
    end
    rready = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ars_stale_beat got %b want 0", seen); end
    ar_send(4'd6, 32'h0, ok);
    r_take(id, d, resp, ok);
    checks++; if ({ok, id, d, resp} !== {1'b1, 4'd6, 32'h0, 2'b00}) begin
      errors++; $display("FAIL ars_fresh_read got %h want %h", {ok, id, d, resp}, {1'b1, 4'd6, 32'h0, 2'b00}); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_errors;
    test_backpressure;
    test_random;
    test_bd_collision;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
